// File: rtl/btn_debouncer.sv
// Push-button debouncer: two-flop synchronizer feeding a four-state debounce FSM that
// reports the clean level, press/release/long-press strobes and an 8-bit press counter.
module btn_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned LONG_CYCLES     = 10000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam int unsigned     CntW     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] DbLast   = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]     HoldLast = 32'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDbPress,
        StHeld,
        StDbRelease
    } state_e;

    logic            r_sync1, r_sync2;
    state_e          r_state, w_state_d;
    logic [CntW-1:0] r_db_cnt, w_db_cnt_d;
    logic [31:0]     r_hold_cnt, w_hold_cnt_d;
    logic            r_long_done, w_long_done_d;
    logic            r_press_pulse, w_press_pulse_d;
    logic            r_release_pulse, w_release_pulse_d;
    logic            r_long_pulse, w_long_pulse_d;
    logic [7:0]      r_press_count, w_press_count_d;
    logic            w_btn_sync;
    logic            w_hold_run;

    assign w_btn_sync = r_sync2;
    assign w_hold_run = (r_state == StHeld) || (r_state == StDbRelease);

    always_comb begin
        w_state_d         = r_state;
        w_db_cnt_d        = r_db_cnt;
        w_hold_cnt_d      = r_hold_cnt;
        w_long_done_d     = r_long_done;
        w_press_pulse_d   = 1'b0;
        w_release_pulse_d = 1'b0;
        w_long_pulse_d    = 1'b0;
        w_press_count_d   = r_press_count;

        // Hold timer keeps running through release bounces; saturates rather than wraps.
        if (w_hold_run) begin
            if (r_hold_cnt != '1) begin
                w_hold_cnt_d = r_hold_cnt + 32'd1;
            end
            if (r_hold_cnt == HoldLast && !r_long_done) begin
                w_long_pulse_d = 1'b1;
                w_long_done_d  = 1'b1;
            end
        end else begin
            w_hold_cnt_d = '0;
        end

        unique case (r_state)
            StIdle: begin
                if (w_btn_sync) begin
                    w_state_d  = StDbPress;
                    w_db_cnt_d = CntW'(1);
                end else begin
                    w_db_cnt_d = '0;
                end
            end
            StDbPress: begin
                if (!w_btn_sync) begin
                    w_state_d  = StIdle;
                    w_db_cnt_d = '0;
                end else if (r_db_cnt == DbLast) begin
                    w_state_d       = StHeld;
                    w_db_cnt_d      = '0;
                    w_hold_cnt_d    = '0;
                    w_press_pulse_d = 1'b1;
                    w_press_count_d = r_press_count + 8'd1;
                end else begin
                    w_db_cnt_d = r_db_cnt + CntW'(1);
                end
            end
            StHeld: begin
                if (!w_btn_sync) begin
                    w_state_d  = StDbRelease;
                    w_db_cnt_d = CntW'(1);
                end
            end
            StDbRelease: begin
                if (w_btn_sync) begin
                    w_state_d  = StHeld;
                    w_db_cnt_d = '0;
                end else if (r_db_cnt == DbLast) begin
                    // Release wins over a coincident long-press expiry so strobes never overlap.
                    w_state_d         = StIdle;
                    w_db_cnt_d        = '0;
                    w_hold_cnt_d      = '0;
                    w_release_pulse_d = 1'b1;
                    w_long_pulse_d    = 1'b0;
                    w_long_done_d     = 1'b0;
                end else begin
                    w_db_cnt_d = r_db_cnt + CntW'(1);
                end
            end
            default: begin
                w_state_d  = StIdle;
                w_db_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1         <= 1'b0;
            r_sync2         <= 1'b0;
            r_state         <= StIdle;
            r_db_cnt        <= '0;
            r_hold_cnt      <= '0;
            r_long_done     <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_press_count   <= '0;
        end else begin
            r_sync1         <= btn_in;
            r_sync2         <= r_sync1;
            r_state         <= w_state_d;
            r_db_cnt        <= w_db_cnt_d;
            r_hold_cnt      <= w_hold_cnt_d;
            r_long_done     <= w_long_done_d;
            r_press_pulse   <= w_press_pulse_d;
            r_release_pulse <= w_release_pulse_d;
            r_long_pulse    <= w_long_pulse_d;
            r_press_count   <= w_press_count_d;
        end
    end

    assign btn_level     = w_hold_run;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign long_pulse    = r_long_pulse;
    assign press_count   = r_press_count;

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with DEBOUNCE_CYCLES=4, LONG_CYCLES=20; edge numbers
// count rising clk edges from the first edge that samples the new btn_in value.
module tb_btn_debouncer;

    logic       clk;
    logic       reset_n;
    logic       btn_in;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    int n_checks;
    int n_fail;
    int exp_count;

    btn_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .press_count  (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clean press and release, 6 edges each, no checking.
    task automatic do_press();
        btn_in = 1'b1;
        repeat (6) tick();
        btn_in = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        btn_in  = 1'b1;
        repeat (3) tick();
        n_checks += 5;
        if (btn_level !== 1'b0) begin
            $display("FAIL reset btn_level: got %b expected 0", btn_level); n_fail++;
        end
        if (press_pulse !== 1'b0) begin
            $display("FAIL reset press_pulse: got %b expected 0", press_pulse); n_fail++;
        end
        if (release_pulse !== 1'b0) begin
            $display("FAIL reset release_pulse: got %b expected 0", release_pulse); n_fail++;
        end
        if (long_pulse !== 1'b0) begin
            $display("FAIL reset long_pulse: got %b expected 0", long_pulse); n_fail++;
        end
        if (press_count !== 8'd0) begin
            $display("FAIL reset press_count: got %0d expected 0", press_count); n_fail++;
        end
        btn_in  = 1'b0;
        reset_n = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (btn_level !== 1'b0) begin
            $display("FAIL reset_idle btn_level: got %b expected 0", btn_level); n_fail++;
        end
        exp_count = 0;
    endtask

    task automatic test_clean_press();
        btn_in = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            n_checks += 2;
            if (press_pulse !== (e == 6)) begin
                $display("FAIL clean_press press_pulse edge %0d: got %b expected %b",
                         e, press_pulse, (e == 6)); n_fail++;
            end
            if (btn_level !== (e >= 6)) begin
                $display("FAIL clean_press btn_level edge %0d: got %b expected %b",
                         e, btn_level, (e >= 6)); n_fail++;
            end
        end
        exp_count++;
        n_checks++;
        if (press_count !== 8'(exp_count)) begin
            $display("FAIL clean_press press_count: got %0d expected %0d", press_count, exp_count);
            n_fail++;
        end
        btn_in = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            n_checks += 3;
            if (release_pulse !== (e == 6)) begin
                $display("FAIL clean_release release_pulse edge %0d: got %b expected %b",
                         e, release_pulse, (e == 6)); n_fail++;
            end
            if (btn_level !== (e < 6)) begin
                $display("FAIL clean_release btn_level edge %0d: got %b expected %b",
                         e, btn_level, (e < 6)); n_fail++;
            end
            if (long_pulse !== 1'b0) begin
                $display("FAIL clean_release long_pulse edge %0d: got %b expected 0",
                         e, long_pulse); n_fail++;
            end
        end
    endtask

    task automatic test_bounce();
        logic exp_p;
        for (int e = 1; e <= 14; e++) begin
            btn_in = (e == 4) ? 1'b0 : 1'b1;
            tick();
            exp_p = (e == 10);
            n_checks++;
            if (press_pulse !== exp_p) begin
                $display("FAIL bounce press_pulse edge %0d: got %b expected %b",
                         e, press_pulse, exp_p); n_fail++;
            end
        end
        exp_count++;
        n_checks++;
        if (press_count !== 8'(exp_count)) begin
            $display("FAIL bounce press_count: got %0d expected %0d", press_count, exp_count);
            n_fail++;
        end
        btn_in = 1'b0;
        repeat (8) tick();
        n_checks++;
        if (btn_level !== 1'b0) begin
            $display("FAIL bounce_release btn_level: got %b expected 0", btn_level); n_fail++;
        end
    endtask

    task automatic test_long_press();
        btn_in = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            n_checks += 2;
            if (press_pulse !== (e == 6)) begin
                $display("FAIL long_press press_pulse edge %0d: got %b expected %b",
                         e, press_pulse, (e == 6)); n_fail++;
            end
            if (long_pulse !== (e == 26)) begin
                $display("FAIL long_press long_pulse edge %0d: got %b expected %b",
                         e, long_pulse, (e == 26)); n_fail++;
            end
        end
        exp_count++;
        btn_in = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            n_checks += 2;
            if (release_pulse !== (e == 6)) begin
                $display("FAIL long_release release_pulse edge %0d: got %b expected %b",
                         e, release_pulse, (e == 6)); n_fail++;
            end
            if (long_pulse !== 1'b0) begin
                $display("FAIL long_release long_pulse edge %0d: got %b expected 0",
                         e, long_pulse); n_fail++;
            end
        end
    endtask

    // Fall sampled at edge 22 puts the FSM in release debounce when the hold timer expires.
    task automatic test_long_in_release();
        for (int e = 1; e <= 32; e++) begin
            btn_in = (e <= 21);
            tick();
            n_checks += 4;
            if (press_pulse !== (e == 6)) begin
                $display("FAIL long_in_release press_pulse edge %0d: got %b expected %b",
                         e, press_pulse, (e == 6)); n_fail++;
            end
            if (long_pulse !== (e == 26)) begin
                $display("FAIL long_in_release long_pulse edge %0d: got %b expected %b",
                         e, long_pulse, (e == 26)); n_fail++;
            end
            if (release_pulse !== (e == 27)) begin
                $display("FAIL long_in_release release_pulse edge %0d: got %b expected %b",
                         e, release_pulse, (e == 27)); n_fail++;
            end
            if (btn_level !== (e >= 6 && e < 27)) begin
                $display("FAIL long_in_release btn_level edge %0d: got %b expected %b",
                         e, btn_level, (e >= 6 && e < 27)); n_fail++;
            end
        end
        exp_count++;
    endtask

    task automatic test_release_glitch();
        btn_in = 1'b1;
        repeat (6) tick();
        exp_count++;
        n_checks++;
        if (btn_level !== 1'b1) begin
            $display("FAIL glitch_press btn_level: got %b expected 1", btn_level); n_fail++;
        end
        for (int e = 1; e <= 10; e++) begin
            btn_in = (e > 2);
            tick();
            n_checks += 2;
            if (btn_level !== 1'b1) begin
                $display("FAIL glitch btn_level edge %0d: got %b expected 1", e, btn_level);
                n_fail++;
            end
            if (release_pulse !== 1'b0) begin
                $display("FAIL glitch release_pulse edge %0d: got %b expected 0",
                         e, release_pulse); n_fail++;
            end
        end
        btn_in = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            n_checks++;
            if (release_pulse !== (e == 6)) begin
                $display("FAIL glitch_release release_pulse edge %0d: got %b expected %b",
                         e, release_pulse, (e == 6)); n_fail++;
            end
        end
    endtask

    task automatic test_wrap();
        int n;
        n = 256 - exp_count;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) begin
                n_checks++;
                if (press_count !== 8'd255) begin
                    $display("FAIL wrap pre press_count: got %0d expected 255", press_count);
                    n_fail++;
                end
            end
            do_press();
        end
        exp_count = 0;
        n_checks++;
        if (press_count !== 8'd0) begin
            $display("FAIL wrap press_count: got %0d expected 0", press_count); n_fail++;
        end
    endtask

    task automatic test_reset_mid_hold();
        btn_in = 1'b1;
        repeat (10) tick();
        exp_count++;
        n_checks += 2;
        if (btn_level !== 1'b1) begin
            $display("FAIL mid_hold pre btn_level: got %b expected 1", btn_level); n_fail++;
        end
        if (press_count !== 8'(exp_count)) begin
            $display("FAIL mid_hold pre press_count: got %0d expected %0d", press_count, exp_count);
            n_fail++;
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_count = 0;
        n_checks += 4;
        if (btn_level !== 1'b0) begin
            $display("FAIL mid_hold btn_level: got %b expected 0", btn_level); n_fail++;
        end
        if (press_count !== 8'd0) begin
            $display("FAIL mid_hold press_count: got %0d expected 0", press_count); n_fail++;
        end
        if (release_pulse !== 1'b0) begin
            $display("FAIL mid_hold release_pulse: got %b expected 0", release_pulse); n_fail++;
        end
        if (press_pulse !== 1'b0) begin
            $display("FAIL mid_hold press_pulse: got %b expected 0", press_pulse); n_fail++;
        end
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_checks += 3;
            if (press_pulse !== (e == 6)) begin
                $display("FAIL mid_hold_repress press_pulse edge %0d: got %b expected %b",
                         e, press_pulse, (e == 6)); n_fail++;
            end
            if (release_pulse !== 1'b0) begin
                $display("FAIL mid_hold_repress release_pulse edge %0d: got %b expected 0",
                         e, release_pulse); n_fail++;
            end
            if (btn_level !== (e >= 6)) begin
                $display("FAIL mid_hold_repress btn_level edge %0d: got %b expected %b",
                         e, btn_level, (e >= 6)); n_fail++;
            end
        end
        exp_count++;
        n_checks++;
        if (press_count !== 8'(exp_count)) begin
            $display("FAIL mid_hold_repress press_count: got %0d expected %0d",
                     press_count, exp_count); n_fail++;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_count = 0;
        reset_n   = 1'b0;
        btn_in    = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_long_in_release();
        test_release_glitch();
        test_wrap();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_debouncer.md
BTN_DEBOUNCER -- requirements
Module: btn_debouncer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 100000, the number of consecutive stable btn_sync samples (10 ms at 10 MHz) needed to accept a level change; legal minimum 2.
REQ-002 The block SHALL have parameter LONG_CYCLES, default 10000000, the number of clk cycles held after press acceptance (1 s at 10 MHz) before a long-press event; it SHALL be greater than DEBOUNCE_CYCLES.
REQ-003 The block SHALL have port clk, input, 1 bit: the 10 MHz clock from the clock wizard; all logic on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset (driven from the MMCM locked output).
REQ-005 The block SHALL have port btn_in, input, 1 bit: raw asynchronous push-button (btnC style), active-high.
REQ-006 The block SHALL have port btn_level, output, 1 bit: the debounced button level.
REQ-007 The block SHALL have port press_pulse, output, 1 bit: a one-cycle strobe on an accepted press.
REQ-008 The block SHALL have port release_pulse, output, 1 bit: a one-cycle strobe on an accepted release.
REQ-009 The block SHALL have port long_pulse, output, 1 bit: a one-cycle strobe when a press is held for LONG_CYCLES.
REQ-010 The block SHALL have port press_count, output, 8 bits: the count of accepted presses.

Function
REQ-011 btn_in SHALL pass through a two-flop synchronizer, giving btn_sync (2-cycle delay); no other logic SHALL sample btn_in directly.
REQ-012 The FSM SHALL have exactly four states: IDLE, DB_PRESS, HELD and DB_RELEASE, with one stability counter (width sufficient for DEBOUNCE_CYCLES).
REQ-013 IDLE behaviour:
- btn_sync=1 -> DB_PRESS, with the stability counter loaded to 1.
- btn_sync=0 -> stay in IDLE.
REQ-014 DB_PRESS behaviour:
- btn_sync=0 -> IDLE, counter cleared, no pulse.
- btn_sync=1 and counter=DEBOUNCE_CYCLES-1 -> HELD; btn_level<=1, press_pulse<=1 for one cycle, press_count increments.
- otherwise the counter increments.
REQ-015 Press latency SHALL be exactly DEBOUNCE_CYCLES+2 clk edges from the first edge sampling btn_in=1, provided btn_in stays high.
REQ-016 HELD SHALL run a 32-bit hold counter, starting at 0 on entry from DB_PRESS.
- When it reaches LONG_CYCLES-1: long_pulse<=1 for one cycle and a long_done flag is set.
- long_pulse SHALL fire at most once per accepted press.
- The hold counter SHALL saturate.
REQ-017 HELD with btn_sync=0 SHALL go to DB_RELEASE, with the stability counter loaded to 1.
REQ-018 DB_RELEASE behaviour:
- btn_sync=1 -> HELD, no pulse, btn_level stays 1.
- btn_sync=0 and counter=DEBOUNCE_CYCLES-1 -> IDLE; btn_level<=0, release_pulse<=1 for one cycle, long_done cleared.
- otherwise the counter increments.
REQ-019 The hold counter and long_pulse logic SHALL keep running during DB_RELEASE.
- If LONG_CYCLES expires there, long_pulse still fires.
- long_done SHALL NOT clear on a bounce back to HELD.
REQ-020 press_count SHALL wrap from 255 to 0 with no flag.
REQ-021 press_pulse, release_pulse and long_pulse SHALL be registered, never asserted together, and 0 in every cycle not named above.
REQ-022 btn_level SHALL be 1 exactly in HELD and DB_RELEASE, and 0 in IDLE and DB_PRESS.

Reset
REQ-023 When reset_n=0 at a rising edge, all state SHALL reset:
- synchronizer flops 0, state IDLE, all counters 0, long_done 0;
- btn_level 0, all pulses 0, press_count 0.
REQ-024 Reset SHALL take priority over all transitions, including mid-debounce and mid-hold; no pulse SHALL be emitted in the release cycle.
REQ-025 After reset deasserts with btn_in held high, a full press debounce (REQ-015) SHALL occur before btn_level=1.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-026 Clean press: btn_in 0->1 held -> press_pulse high exactly on edge 6, btn_level=1 from edge 6, press_count=1.
REQ-027 Bounce: btn_in high 3 cycles, low 1, high 10 -> no pulse during the first burst; one press_pulse 6 edges after the final rise.
REQ-028 Long press: hold 40 cycles, then release -> one long_pulse 20 cycles after press_pulse; release_pulse 6 edges after the fall; no second long_pulse.
REQ-029 Release glitch: in HELD, btn_in low 2 cycles then high -> btn_level stays 1, no release_pulse.
REQ-030 Wrap: 256 clean presses -> press_count returns to 0.
REQ-031 Reset mid-hold: reset_n=0 for one edge while in HELD -> all outputs 0 on the next cycle, no release_pulse; with btn_in still high, press_pulse recurs 6 edges after reset_n=1.
